noc_host_port: RTL and testbench
================================

Name: noc_host_port

Overview:
- Host-side end of the byte-serial NoC device protocol: serializes read/write commands onto noc_to_dev_ctl/noc_to_dev_data and parses device responses from noc_from_dev_ctl/noc_from_dev_data.
- Sits between the testbench/host controller and the perm-device interface; one outstanding command at a time, with a response timeout.

Parameters:
- TIMEOUT, 4096, cycles from last command byte to required response before rsp_timeout fires.
- WBUF_BYTES, 128, write-data staging buffer depth (max Dlen).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- req_valid  in  1  command request.
- req_ready  out  1  tx idle and no command outstanding.
- req_write  in  1  1 = write (cmd 3'b010), 0 = read (cmd 3'b001).
- req_alen  in  2  address length code: 0/1/2/3 = 1/2/4/8 bytes.
- req_dlen  in  3  data length code: n -> 2^n bytes (1..128).
- req_dest  in  8  destination ID, nonzero.
- req_src  in  8  source ID, nonzero.
- req_addr  in  64  address, byte 0 (LSB) sent first.
- wr_valid / wr_ready / wr_byte  in/out/in  1/1/8  write-data byte stream, first byte = lowest index.
- noc_to_dev_ctl  out  1  header flag.
- noc_to_dev_data  out  8  command byte stream.
- noc_from_dev_ctl  in  1  response header flag.
- noc_from_dev_data  in  8  response byte stream.
- rsp_valid  out  1  one-cycle pulse: read/write response complete.
- rsp_kind  out  1  0 = read response, 1 = write response.
- rsp_rc  out  2  response header bits [7:6].
- rsp_len  out  8  write: actual-length byte; read: bytes received.
- rd_valid / rd_byte  out/out  1/8  read-response data bytes, one per cycle.
- msg_valid  out  1  pulse: message received.
- msg_addr / msg_data  out  8/8  message address and data.
- rsp_err  out  1  pulse: malformed response.
- rsp_timeout  out  1  pulse: no response within TIMEOUT.

Behaviour:
- Reset: all outputs 0 except req_ready = 1. Both FSMs idle, outstanding = 0, timeout counter = 0, buffer index = 0.
- Header byte: {alen, dlen, cmd}.
  - Read response cmd 3'b011: {rc, dlen, 011}, dest, src, then 2^dlen data bytes.
  - Write response cmd 3'b100: {rc, 000, 100}, dest, src, length byte.
  - Message cmd 3'b101: 0x05, dest, src, addr, data.
- TX FSM T_IDLE -> [T_LOAD] -> T_HDR -> T_DEST -> T_SRC -> T_ADDR -> [T_DATA] -> T_IDLE.
  - Accept on req_valid & req_ready (cycle N); latch all req fields; set outstanding.
  - Write: T_LOAD asserts wr_ready and stores 2^dlen bytes (stalls on wr_valid = 0). Header is sent the cycle after the last byte is loaded.
  - Read: header at N+1.
  - Then dest, src, addr bytes (alen count) and write data, one byte per cycle, no bubbles.
  - ctl = 1 only in the header cycle; data = 0 when idle.
- Timeout counter starts after the final TX byte. Cleared by a read/write response.
  - At TIMEOUT: rsp_timeout pulse, outstanding cleared.
- RX FSM R_IDLE, R_DEST, R_SRC, R_BODY, R_MSGDATA. Runs independently of TX; parses even during TX.
  - R_IDLE: ctl = 1 decodes cmd.
  - Unknown cmd, or a byte with ctl = 0 in idle: ignored; an unknown cmd with ctl = 1 raises rsp_err.
  - R_DEST / R_SRC: a zero byte -> rsp_err, return to R_IDLE.
  - R_BODY, write response: length byte -> rsp_valid next cycle with rsp_kind = 1, rsp_len = byte; outstanding cleared.
  - R_BODY, read response: rd_valid/rd_byte registered one cycle after each input byte; rsp_valid with final count, outstanding cleared.
  - Message: addr in R_BODY, data in R_MSGDATA -> msg_valid. Does not clear outstanding.
- ctl = 1 mid-packet: rsp_err pulse, and that byte is decoded as a new header in the same cycle.
- Simultaneous timeout and response completion in the same cycle: response wins, no rsp_timeout.
- Reset mid-operation: abandons both packets immediately; wbuf contents don't care.
- Widths:
  - Byte counters are 8 bits; read count 128 fits in 8 bits.
  - Timeout counter is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Package noc_pkg holds:
  - cmd codes CMD_READ = 3'b001, CMD_WRITE = 3'b010, CMD_RDRSP = 3'b011, CMD_WRRSP = 3'b100, CMD_MSG = 3'b101;
  - alen/dlen decode functions;
  - tx_state_t and rx_state_t enums.
- Sub-module noc_rsp_parser (RX FSM plus outputs); TX and timeout stay in the top.

Test Plan:
- Read, alen = 1, dlen = 0, dest 0x11, src 0x22, addr 0xBEEF -> stream 0x41(ctl), 0x11, 0x22, 0xEF, 0xBE; req_ready low until a response arrives.
- Write, alen = 0, dlen = 2, bytes 01..04 with wr_valid gaps -> no gaps on the NoC.
  - Stream 0x12(ctl), dest, src, addr, 01, 02, 03, 04.
  - Inject response 0x84, 0x22, 0x11, 0x04 -> rsp_valid, rsp_kind = 1, rc = 2, len = 4, req_ready = 1.
- Message 0x05, 0x22, 0x11, 0x42, 0x78 mid-outstanding -> msg_valid with addr 0x42, data 0x78; outstanding kept.
- Response with zero dest byte -> rsp_err; a following valid write response is still parsed.
- No response, TIMEOUT = 16 -> rsp_timeout exactly 16 cycles after the last TX byte; req_ready = 1.
- Drop rst low during T_ADDR -> ctl/data 0 immediately; req_ready = 1 after release.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared command codes, length decoders and FSM state types for the NoC host port.
package noc_pkg;

    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b010;
    localparam logic [2:0] CMD_RDRSP = 3'b011;
    localparam logic [2:0] CMD_WRRSP = 3'b100;
    localparam logic [2:0] CMD_MSG   = 3'b101;

    typedef enum logic [2:0] {
        T_IDLE,
        T_LOAD,
        T_HDR,
        T_DEST,
        T_SRC,
        T_ADDR,
        T_DATA
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_DEST,
        R_SRC,
        R_BODY,
        R_MSGDATA
    } rx_state_t;

    // Address length code 0..3 -> 1/2/4/8 bytes.
    function automatic logic [7:0] alen_bytes(input logic [1:0] alen);
        return 8'd1 << alen;
    endfunction

    // Data length code n -> 2^n bytes (1..128).
    function automatic logic [7:0] dlen_bytes(input logic [2:0] dlen);
        return 8'd1 << dlen;
    endfunction

endpackage

// File: rtl/noc_host_port_if.sv
// Host request/response signals and the byte-serial NoC link, bundled for the host port.
interface noc_host_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_alen;
    logic [2:0]  req_dlen;
    logic [7:0]  req_dest;
    logic [7:0]  req_src;
    logic [63:0] req_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_byte;
    logic        noc_to_dev_ctl;
    logic [7:0]  noc_to_dev_data;
    logic        noc_from_dev_ctl;
    logic [7:0]  noc_from_dev_data;
    logic        rsp_valid;
    logic        rsp_kind;
    logic [1:0]  rsp_rc;
    logic [7:0]  rsp_len;
    logic        rd_valid;
    logic [7:0]  rd_byte;
    logic        msg_valid;
    logic [7:0]  msg_addr;
    logic [7:0]  msg_data;
    logic        rsp_err;
    logic        rsp_timeout;

    // Host controller / device model side.
    modport master (
        output req_valid, req_write, req_alen, req_dlen, req_dest, req_src, req_addr,
        output wr_valid, wr_byte, noc_from_dev_ctl, noc_from_dev_data,
        input  req_ready, wr_ready, noc_to_dev_ctl, noc_to_dev_data,
        input  rsp_valid, rsp_kind, rsp_rc, rsp_len, rd_valid, rd_byte,
        input  msg_valid, msg_addr, msg_data, rsp_err, rsp_timeout
    );

    // Host port side.
    modport slave (
        input  req_valid, req_write, req_alen, req_dlen, req_dest, req_src, req_addr,
        input  wr_valid, wr_byte, noc_from_dev_ctl, noc_from_dev_data,
        output req_ready, wr_ready, noc_to_dev_ctl, noc_to_dev_data,
        output rsp_valid, rsp_kind, rsp_rc, rsp_len, rd_valid, rd_byte,
        output msg_valid, msg_addr, msg_data, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/noc_rsp_parser.sv
// Device-to-host response parser: decodes read/write responses and messages byte by byte.
//
// state     | meaning
// R_IDLE    | waiting for a header byte (ctl = 1)
// R_DEST    | expecting nonzero destination ID
// R_SRC     | expecting nonzero source ID
// R_BODY    | write length byte, read data bytes, or message address
// R_MSGDATA | expecting message data byte
module noc_rsp_parser
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ctl,
    input  logic [7:0] i_data,
    output logic       o_rsp_valid,
    output logic       o_rsp_kind,
    output logic [1:0] o_rsp_rc,
    output logic [7:0] o_rsp_len,
    output logic       o_rd_valid,
    output logic [7:0] o_rd_byte,
    output logic       o_msg_valid,
    output logic [7:0] o_msg_addr,
    output logic [7:0] o_msg_data,
    output logic       o_rsp_err,
    output logic       o_rsp_done
);

    rx_state_t  r_state, w_state_nxt;
    logic [2:0] r_cmd, w_cmd_nxt;
    logic [1:0] r_rc, w_rc_nxt;
    logic [2:0] r_dlen, w_dlen_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_addr, w_addr_nxt;
    logic [7:0] w_cnt_inc;
    logic       w_rsp_valid, w_rsp_kind, w_rd_valid, w_msg_valid, w_err;
    logic [7:0] w_len;

    assign w_cnt_inc  = r_cnt + 8'd1;
    assign o_rsp_done = w_rsp_valid;

    // Next-state and pulse decode; a header byte restarts parsing from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_rc_nxt    = r_rc;
        w_dlen_nxt  = r_dlen;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_rsp_valid = 1'b0;
        w_rsp_kind  = 1'b0;
        w_len       = 8'd0;
        w_rd_valid  = 1'b0;
        w_msg_valid = 1'b0;
        w_err       = 1'b0;
        if (i_ctl) begin
            w_err      = (r_state != R_IDLE);
            w_cmd_nxt  = i_data[2:0];
            w_rc_nxt   = i_data[7:6];
            w_dlen_nxt = i_data[5:3];
            w_cnt_nxt  = 8'd0;
            case (i_data[2:0])
                CMD_RDRSP, CMD_WRRSP, CMD_MSG: w_state_nxt = R_DEST;
                default: begin
                    w_err       = 1'b1;
                    w_state_nxt = R_IDLE;
                end
            endcase
        end else begin
            case (r_state)
                R_DEST: begin
                    w_err       = (i_data == 8'd0);
                    w_state_nxt = (i_data == 8'd0) ? R_IDLE : R_SRC;
                end
                R_SRC: begin
                    w_err       = (i_data == 8'd0);
                    w_state_nxt = (i_data == 8'd0) ? R_IDLE : R_BODY;
                end
                R_BODY: begin
                    case (r_cmd)
                        CMD_WRRSP: begin
                            w_rsp_valid = 1'b1;
                            w_rsp_kind  = 1'b1;
                            w_len       = i_data;
                            w_state_nxt = R_IDLE;
                        end
                        CMD_RDRSP: begin
                            w_rd_valid = 1'b1;
                            w_cnt_nxt  = w_cnt_inc;
                            if (w_cnt_inc == dlen_bytes(r_dlen)) begin
                                w_rsp_valid = 1'b1;
                                w_len       = w_cnt_inc;
                                w_state_nxt = R_IDLE;
                            end
                        end
                        default: begin
                            w_addr_nxt  = i_data;
                            w_state_nxt = R_MSGDATA;
                        end
                    endcase
                end
                R_MSGDATA: begin
                    w_msg_valid = 1'b1;
                    w_state_nxt = R_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Parser state and packet scratch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_cmd   <= 3'd0;
            r_rc    <= 2'd0;
            r_dlen  <= 3'd0;
            r_cnt   <= 8'd0;
            r_addr  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_rc    <= w_rc_nxt;
            r_dlen  <= w_dlen_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Registered host-facing outputs, one cycle behind the byte that produced them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_kind  <= 1'b0;
            o_rsp_rc    <= 2'd0;
            o_rsp_len   <= 8'd0;
            o_rd_valid  <= 1'b0;
            o_rd_byte   <= 8'd0;
            o_msg_valid <= 1'b0;
            o_msg_addr  <= 8'd0;
            o_msg_data  <= 8'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            o_rsp_valid <= w_rsp_valid;
            o_rd_valid  <= w_rd_valid;
            o_msg_valid <= w_msg_valid;
            o_rsp_err   <= w_err;
            if (w_rsp_valid) begin
                o_rsp_kind <= w_rsp_kind;
                o_rsp_rc   <= r_rc;
                o_rsp_len  <= w_len;
            end
            if (w_rd_valid) o_rd_byte <= i_data;
            if (w_msg_valid) begin
                o_msg_addr <= r_addr;
                o_msg_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/noc_host_port.sv
// Host end of the byte-serial NoC link: command serializer, write staging buffer and response timeout.
//
// state  | meaning
// T_IDLE | no command in flight on the link
// T_LOAD | collecting write data into the staging buffer
// T_HDR  | sending header {alen, dlen, cmd} with ctl = 1
// T_DEST | sending destination ID
// T_SRC  | sending source ID
// T_ADDR | sending address bytes, LSB first
// T_DATA | sending staged write data
module noc_host_port
    import noc_pkg::*;
#(
    parameter int TIMEOUT    = 4096,
    parameter int WBUF_BYTES = 128
) (
    input  logic            clk,
    input  logic            rst,
    noc_host_port_if.slave  bus
);

    localparam int IDXW = (WBUF_BYTES > 1) ? $clog2(WBUF_BYTES) : 1;
    localparam int TMW  = $clog2(TIMEOUT + 1);
    // The counter starts at 1 on the cycle after the last byte, so TIMEOUT must be at least 2.
    localparam logic [TMW-1:0] TMO_MAX  = TMW'(TIMEOUT);
    localparam logic [TMW-1:0] TMO_FIRE = TMW'(TIMEOUT - 1);

    tx_state_t       r_tx, w_tx_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic            r_write;
    logic [1:0]      r_alen;
    logic [2:0]      r_dlen;
    logic [7:0]      r_dest, r_src;
    logic [63:0]     r_addr;
    logic [7:0]      r_wbuf [WBUF_BYTES];
    logic            r_outstanding;
    logic            r_tmo_run;
    logic [TMW-1:0]  r_tmo_cnt;
    logic            r_tmo_pulse;
    logic            w_accept, w_wr_en, w_last_byte, w_ctl, w_wr_ready, w_rsp_done;
    logic [7:0]      w_data;

    assign bus.req_ready       = (r_tx == T_IDLE) && !r_outstanding;
    assign bus.wr_ready        = w_wr_ready;
    assign bus.noc_to_dev_ctl  = w_ctl;
    assign bus.noc_to_dev_data = w_data;
    assign bus.rsp_timeout     = r_tmo_pulse;

    // Transmit sequencing and the byte presented on the link this cycle.
    always_comb begin
        w_tx_nxt    = r_tx;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_wr_en     = 1'b0;
        w_last_byte = 1'b0;
        w_ctl       = 1'b0;
        w_data      = 8'd0;
        w_wr_ready  = 1'b0;
        case (r_tx)
            T_IDLE: begin
                if (bus.req_valid && !r_outstanding) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = 8'd0;
                    w_tx_nxt  = bus.req_write ? T_LOAD : T_HDR;
                end
            end
            T_LOAD: begin
                w_wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    w_wr_en   = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == dlen_bytes(r_dlen) - 8'd1) begin
                        w_cnt_nxt = 8'd0;
                        w_tx_nxt  = T_HDR;
                    end
                end
            end
            T_HDR: begin
                w_ctl    = 1'b1;
                w_data   = {r_alen, r_dlen, r_write ? CMD_WRITE : CMD_READ};
                w_tx_nxt = T_DEST;
            end
            T_DEST: begin
                w_data   = r_dest;
                w_tx_nxt = T_SRC;
            end
            T_SRC: begin
                w_data    = r_src;
                w_cnt_nxt = 8'd0;
                w_tx_nxt  = T_ADDR;
            end
            T_ADDR: begin
                w_data    = r_addr[{r_cnt[2:0], 3'b000} +: 8];
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == alen_bytes(r_alen) - 8'd1) begin
                    w_cnt_nxt = 8'd0;
                    if (r_write) begin
                        w_tx_nxt = T_DATA;
                    end else begin
                        w_last_byte = 1'b1;
                        w_tx_nxt    = T_IDLE;
                    end
                end
            end
            T_DATA: begin
                w_data    = r_wbuf[r_cnt[IDXW-1:0]];
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == dlen_bytes(r_dlen) - 8'd1) begin
                    w_cnt_nxt   = 8'd0;
                    w_last_byte = 1'b1;
                    w_tx_nxt    = T_IDLE;
                end
            end
            default: w_tx_nxt = T_IDLE;
        endcase
    end

    // Transmit state register and byte counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx  <= T_IDLE;
            r_cnt <= 8'd0;
        end else begin
            r_tx  <= w_tx_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Request fields are held for the whole command once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write <= 1'b0;
            r_alen  <= 2'd0;
            r_dlen  <= 3'd0;
            r_dest  <= 8'd0;
            r_src   <= 8'd0;
            r_addr  <= 64'd0;
        end else if (w_accept) begin
            r_write <= bus.req_write;
            r_alen  <= bus.req_alen;
            r_dlen  <= bus.req_dlen;
            r_dest  <= bus.req_dest;
            r_src   <= bus.req_src;
            r_addr  <= bus.req_addr;
        end
    end

    // Write staging buffer; contents are meaningless outside a write command, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_wbuf[r_cnt[IDXW-1:0]] <= bus.wr_byte;
    end

    // Outstanding flag and response timeout; a completing response beats a same-cycle expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= 1'b0;
            r_tmo_run     <= 1'b0;
            r_tmo_cnt     <= '0;
            r_tmo_pulse   <= 1'b0;
        end else begin
            r_tmo_pulse <= 1'b0;
            if (w_accept) r_outstanding <= 1'b1;
            else if (w_rsp_done) r_outstanding <= 1'b0;
            if (w_rsp_done) begin
                r_tmo_run <= 1'b0;
                r_tmo_cnt <= '0;
            end else if (w_last_byte && r_outstanding) begin
                r_tmo_run <= 1'b1;
                r_tmo_cnt <= TMW'(1);
            end else if (r_tmo_run) begin
                if (r_tmo_cnt != TMO_MAX) r_tmo_cnt <= r_tmo_cnt + TMW'(1);
                if (r_tmo_cnt == TMO_FIRE) begin
                    r_tmo_pulse   <= 1'b1;
                    r_tmo_run     <= 1'b0;
                    r_outstanding <= 1'b0;
                end
            end
        end
    end

    noc_rsp_parser u_parser (
        .clk         (clk),
        .rst         (rst),
        .i_ctl       (bus.noc_from_dev_ctl),
        .i_data      (bus.noc_from_dev_data),
        .o_rsp_valid (bus.rsp_valid),
        .o_rsp_kind  (bus.rsp_kind),
        .o_rsp_rc    (bus.rsp_rc),
        .o_rsp_len   (bus.rsp_len),
        .o_rd_valid  (bus.rd_valid),
        .o_rd_byte   (bus.rd_byte),
        .o_msg_valid (bus.msg_valid),
        .o_msg_addr  (bus.msg_addr),
        .o_msg_data  (bus.msg_data),
        .o_rsp_err   (bus.rsp_err),
        .o_rsp_done  (w_rsp_done)
    );

endmodule

// File: tb/tb_noc_host_port.sv
// Testbench for noc_host_port: scoreboard queues for link bytes, responses, read data and messages.
module tb_noc_host_port;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    noc_host_port_if bus();

    noc_host_port #(.TIMEOUT(TMO), .WBUF_BYTES(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_err  = 0;
    int n_tmo  = 0;

    logic [8:0]  tx_q[$];   // {ctl, data} expected on the link
    logic [7:0]  rd_q[$];
    logic [10:0] rsp_q[$];  // {kind, rc, len}
    logic [15:0] msg_q[$];  // {addr, data}
    logic [7:0]  wdata[$];

    // Response-side scoreboard: pops an expectation whenever the DUT pulses an output.
    always @(negedge clk) begin
        logic [10:0] er;
        logic [15:0] em;
        logic [7:0]  eb;
        if (rst) begin
            if (bus.rd_valid) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_byte: unexpected byte %02h, none expected", bus.rd_byte);
                end else begin
                    eb = rd_q.pop_front();
                    if (bus.rd_byte !== eb) begin
                        errors++;
                        $display("FAIL rd_byte: got %02h want %02h", bus.rd_byte, eb);
                    end
                end
            end
            if (bus.rsp_valid) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp: unexpected kind=%0d rc=%0d len=%0d", bus.rsp_kind, bus.rsp_rc, bus.rsp_len);
                end else begin
                    er = rsp_q.pop_front();
                    if ({bus.rsp_kind, bus.rsp_rc, bus.rsp_len} !== er) begin
                        errors++;
                        $display("FAIL rsp: got kind=%0d rc=%0d len=%0d want kind=%0d rc=%0d len=%0d",
                                 bus.rsp_kind, bus.rsp_rc, bus.rsp_len, er[10], er[9:8], er[7:0]);
                    end
                end
            end
            if (bus.msg_valid) begin
                checks++;
                if (msg_q.size() == 0) begin
                    errors++;
                    $display("FAIL msg: unexpected addr=%02h data=%02h", bus.msg_addr, bus.msg_data);
                end else begin
                    em = msg_q.pop_front();
                    if ({bus.msg_addr, bus.msg_data} !== em) begin
                        errors++;
                        $display("FAIL msg: got addr=%02h data=%02h want addr=%02h data=%02h",
                                 bus.msg_addr, bus.msg_data, em[15:8], em[7:0]);
                    end
                end
            end
            if (bus.rsp_err) n_err++;
            if (bus.rsp_timeout) n_tmo++;
        end
    end

    task automatic drive_idle();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_alen = 2'd0; bus.req_dlen = 3'd0;
        bus.req_dest = 8'd0; bus.req_src = 8'd0; bus.req_addr = 64'd0;
        bus.wr_valid = 1'b0; bus.wr_byte = 8'd0;
        bus.noc_from_dev_ctl = 1'b0; bus.noc_from_dev_data = 8'd0;
    endtask

    task automatic dev_byte(input logic c, input logic [7:0] d);
        bus.noc_from_dev_ctl  = c;
        bus.noc_from_dev_data = d;
        @(negedge clk);
        bus.noc_from_dev_ctl  = 1'b0;
        bus.noc_from_dev_data = 8'd0;
    endtask

    // Queue the byte stream a command should produce, built from the header formula.
    task automatic expect_cmd(input logic wr, input logic [1:0] alen, input logic [2:0] dlen,
                              input logic [7:0] dest, input logic [7:0] src, input logic [63:0] addr);
        logic [63:0] a;
        a = addr;
        tx_q.push_back({1'b1, alen, dlen, wr ? 3'b010 : 3'b001});
        tx_q.push_back({1'b0, dest});
        tx_q.push_back({1'b0, src});
        for (int i = 0; i < (1 << alen); i++) begin
            tx_q.push_back({1'b0, a[7:0]});
            a = a >> 8;
        end
        if (wr) foreach (wdata[i]) tx_q.push_back({1'b0, wdata[i]});
        tx_q.push_back(9'h000);
    endtask

    task automatic issue(input logic wr, input logic [1:0] alen, input logic [2:0] dlen,
                         input logic [7:0] dest, input logic [7:0] src, input logic [63:0] addr);
        bus.req_write = wr; bus.req_alen = alen; bus.req_dlen = dlen;
        bus.req_dest = dest; bus.req_src = src; bus.req_addr = addr;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Waits (bounded) for the header, then compares consecutive link cycles; ends on the idle cycle.
    task automatic check_tx(input string name);
        int w;
        logic [8:0] e;
        w = 0;
        while (bus.noc_to_dev_ctl !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus.noc_to_dev_ctl !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: no header after %0d cycles", name, w);
            tx_q.delete();
            return;
        end
        while (tx_q.size() > 0) begin
            e = tx_q.pop_front();
            checks++;
            if ({bus.noc_to_dev_ctl, bus.noc_to_dev_data} !== e) begin
                errors++;
                $display("FAIL %s_byte: got ctl=%0d data=%02h want ctl=%0d data=%02h",
                         name, bus.noc_to_dev_ctl, bus.noc_to_dev_data, e[8], e[7:0]);
            end
            if (tx_q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %0d want 1", bus.req_ready);
        end
        checks++;
        if ({bus.noc_to_dev_ctl, bus.noc_to_dev_data, bus.wr_ready} !== 10'd0) begin
            errors++; $display("FAIL reset_link: got ctl=%0d data=%02h wr_ready=%0d want 0",
                               bus.noc_to_dev_ctl, bus.noc_to_dev_data, bus.wr_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.rd_valid, bus.msg_valid, bus.rsp_err, bus.rsp_timeout,
             bus.rsp_kind, bus.rsp_rc, bus.rsp_len, bus.rd_byte, bus.msg_addr, bus.msg_data} !== '0) begin
            errors++; $display("FAIL reset_rsp_outputs: got nonzero want all 0");
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        expect_cmd(1'b0, 2'd1, 3'd0, 8'h11, 8'h22, 64'hBEEF);
        issue(1'b0, 2'd1, 3'd0, 8'h11, 8'h22, 64'hBEEF);
        check_tx("read");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 1'b0) begin
                errors++; $display("FAIL read_outstanding: req_ready got %0d want 0", bus.req_ready);
            end
        end
        rsp_q.push_back({1'b0, 2'd1, 8'd4});
        dev_byte(1'b1, 8'h53);
        dev_byte(1'b0, 8'h22);
        dev_byte(1'b0, 8'h11);
        for (int i = 0; i < 4; i++) begin
            rd_q.push_back(8'hA0 + 8'(i));
            dev_byte(1'b0, 8'hA0 + 8'(i));
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL read_done_ready: got %0d want 1", bus.req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_write_msg();
        int base_err, base_tmo;
        base_err = n_err;
        base_tmo = n_tmo;
        wdata = '{8'h01, 8'h02, 8'h03, 8'h04};
        expect_cmd(1'b1, 2'd0, 3'd2, 8'h33, 8'h44, 64'h5A);
        issue(1'b1, 2'd0, 3'd2, 8'h33, 8'h44, 64'h5A);
        checks++;
        if ({bus.wr_ready, bus.req_ready} !== 2'b10) begin
            errors++; $display("FAIL write_load: wr_ready=%0d req_ready=%0d want 1 0", bus.wr_ready, bus.req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_byte  = wdata[i];
            @(negedge clk);
            bus.wr_valid = 1'b0;
            if (i % 2 == 0) begin
                @(negedge clk);
                @(negedge clk);
            end
        end
        checks++;
        if (bus.wr_ready !== 1'b0) begin
            errors++; $display("FAIL write_loaded: wr_ready got %0d want 0", bus.wr_ready);
        end
        check_tx("write");
        msg_q.push_back({8'h42, 8'h78});
        dev_byte(1'b1, 8'h05);
        dev_byte(1'b0, 8'h22);
        dev_byte(1'b0, 8'h11);
        dev_byte(1'b0, 8'h42);
        dev_byte(1'b0, 8'h78);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL msg_keeps_outstanding: req_ready got %0d want 0", bus.req_ready);
        end
        rsp_q.push_back({1'b1, 2'd2, 8'd4});
        dev_byte(1'b1, 8'h84);
        dev_byte(1'b0, 8'h22);
        dev_byte(1'b0, 8'h11);
        dev_byte(1'b0, 8'h04);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL write_done_ready: got %0d want 1", bus.req_ready);
        end
        repeat (20) @(negedge clk);
        checks++;
        if ((n_tmo - base_tmo) !== 0 || (n_err - base_err) !== 0) begin
            errors++; $display("FAIL write_no_side_pulses: timeouts %0d errs %0d want 0 0",
                               n_tmo - base_tmo, n_err - base_err);
        end
    endtask

    task automatic test_errors();
        int base;
        base = n_err;
        dev_byte(1'b0, 8'h55);
        dev_byte(1'b1, 8'h84);
        dev_byte(1'b0, 8'h00);
        rsp_q.push_back({1'b1, 2'd3, 8'd7});
        dev_byte(1'b1, 8'hC4);
        dev_byte(1'b0, 8'h22);
        dev_byte(1'b0, 8'h11);
        dev_byte(1'b0, 8'h07);
        @(negedge clk);
        checks++;
        if ((n_err - base) !== 1) begin
            errors++; $display("FAIL zero_dest_err: got %0d pulses want 1", n_err - base);
        end
        dev_byte(1'b1, 8'h07);
        rsp_q.push_back({1'b1, 2'd3, 8'd9});
        dev_byte(1'b1, 8'h84);
        dev_byte(1'b0, 8'h22);
        dev_byte(1'b1, 8'hC4);
        dev_byte(1'b0, 8'h22);
        dev_byte(1'b0, 8'h11);
        dev_byte(1'b0, 8'h09);
        @(negedge clk);
        checks++;
        if ((n_err - base) !== 3) begin
            errors++; $display("FAIL unknown_and_midpkt_err: got %0d pulses want 3", n_err - base);
        end
    endtask

    task automatic test_rd_max();
        rsp_q.push_back({1'b0, 2'd0, 8'h80});
        dev_byte(1'b1, 8'h3B);
        dev_byte(1'b0, 8'h22);
        dev_byte(1'b0, 8'h11);
        for (int i = 0; i < 128; i++) begin
            rd_q.push_back(8'(i * 3 + 1));
            dev_byte(1'b0, 8'(i * 3 + 1));
        end
        @(negedge clk);
        checks++;
        if (rd_q.size() !== 0 || rsp_q.size() !== 0) begin
            errors++; $display("FAIL rd_max_drain: rd left %0d rsp left %0d want 0 0", rd_q.size(), rsp_q.size());
        end
    endtask

    task automatic test_timeout();
        int first, pulses;
        logic rdy;
        first = -1; pulses = 0; rdy = 1'b0;
        expect_cmd(1'b0, 2'd0, 3'd0, 8'h01, 8'h02, 64'h77);
        issue(1'b0, 2'd0, 3'd0, 8'h01, 8'h02, 64'h77);
        check_tx("tmo_cmd");
        // The idle cycle just checked is one cycle after the final byte.
        for (int k = 1; k <= 24; k++) begin
            if (bus.rsp_timeout) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    rdy = bus.req_ready;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (first !== TMO || pulses !== 1) begin
            errors++; $display("FAIL timeout_cycle: first pulse at %0d (%0d pulses) want %0d (1 pulse)", first, pulses, TMO);
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++; $display("FAIL timeout_ready: got %0d want 1", rdy);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        w = 0;
        issue(1'b0, 2'd3, 3'd0, 8'h05, 8'h06, 64'h0102030405060708);
        while (bus.noc_to_dev_ctl !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.noc_to_dev_data !== 8'h08) begin
            errors++; $display("FAIL rstmid_addr0: got %02h want 08", bus.noc_to_dev_data);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.noc_to_dev_ctl, bus.noc_to_dev_data} !== 9'd0) begin
            errors++; $display("FAIL rstmid_link: got ctl=%0d data=%02h want 0 00", bus.noc_to_dev_ctl, bus.noc_to_dev_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.noc_to_dev_data !== 8'd0) begin
            errors++; $display("FAIL rstmid_release: req_ready=%0d data=%02h want 1 00", bus.req_ready, bus.noc_to_dev_data);
        end
        expect_cmd(1'b0, 2'd0, 3'd1, 8'h09, 8'h0A, 64'h33);
        issue(1'b0, 2'd0, 3'd1, 8'h09, 8'h0A, 64'h33);
        check_tx("after_reset");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_msg();
        test_errors();
        test_rd_max();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (rd_q.size() !== 0 || rsp_q.size() !== 0 || msg_q.size() !== 0) begin
            errors++; $display("FAIL final_drain: rd %0d rsp %0d msg %0d left want 0", rd_q.size(), rsp_q.size(), msg_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
